// File: rtl/queue_fifo_if.sv
// ---------------------------------------------------------------------------
// queue_fifo_if : handshake/data bundle for queue_fifo.
//
//   data   : word to enqueue                          (master -> slave)
//   push   : enqueue strobe, one entry per cycle       (master -> slave)
//   pop    : dequeue strobe, one entry per cycle       (master -> slave)
//   out    : registered head word loaded by a pop      (slave  -> master)
//   full   : count == DEPTH                            (slave  -> master)
//   empty  : count == 0                                (slave  -> master)
//   count  : number of stored entries, 0..DEPTH        (slave  -> master)
//
// With QUEUE_FIFO_ERR_EN defined, two extra slave outputs exist:
//   overflow  : pulse after a push rejected because the queue was full
//   underflow : pulse after a pop rejected because the queue was empty
// ---------------------------------------------------------------------------
interface queue_fifo_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic [WIDTH-1:0]  data;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  out;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
`ifdef QUEUE_FIFO_ERR_EN
    logic              overflow;
    logic              underflow;
`endif

    // Requester side: drives strobes and data, observes status.
    modport master (
        output data, push, pop,
        input  out, full, empty, count
`ifdef QUEUE_FIFO_ERR_EN
        , input overflow, underflow
`endif
    );

    // Queue side.
    modport slave (
        input  data, push, pop,
        output out, full, empty, count
`ifdef QUEUE_FIFO_ERR_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/queue_fifo.sv
// ---------------------------------------------------------------------------
// queue_fifo : circular-buffer FIFO with a registered head output.
//
// Order-preserving companion to the LIFO stack; same strobe handshake.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : asynchronous, active-low reset
//   q      : queue_fifo_if.slave (data/push/pop in; out/full/empty/count out)
//
// Parameters:
//   WIDTH  : data word width
//   DEPTH  : number of entries, power of two, >= 2
//   ADDR_W : pointer width, log2(DEPTH)
//
// Optional feature macro: QUEUE_FIFO_ERR_EN adds registered overflow /
// underflow pulses for rejected push / pop requests. Datapath behaviour is
// identical with or without it.
// ---------------------------------------------------------------------------
module queue_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic         clk,
    input logic         reset,
    queue_fifo_if.slave q
);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH) begin : g_bad_cfg
        $error("queue_fifo: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
    end

    // Storage is deliberately not reset; pop is never accepted while empty,
    // so unwritten entries can never reach out.
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt;
    logic [WIDTH-1:0]  out_r;
    logic              full_r;
    logic              empty_r;

    logic              push_ok;
    logic              pop_ok;

    // A push into a full queue is still accepted when a pop frees the head
    // slot in the same cycle. Pop never bypasses an in-flight push.
    assign push_ok = q.push && (!full_r || q.pop);
    assign pop_ok  = q.pop  && !empty_r;

    always_comb begin
        count_nxt = count_r;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_r + CNT_ONE;
            2'b01:   count_nxt = count_r - CNT_ONE;
            default: count_nxt = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in();
        end
    end

    function automatic logic [WIDTH-1:0] data_in();
        return q.data;
    endfunction

    // When full with push+pop, wr_ptr == rd_ptr: the read below samples the
    // old head before the write lands, which is exactly the required order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            out_r   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                out_r  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_r <= count_nxt;
            // Flags decode the next count so they line up with count.
            full_r  <= (count_nxt == CNT_FULL);
            empty_r <= (count_nxt == '0);
        end
    end

    assign q.out   = out_r;
    assign q.count = count_r;
    assign q.full  = full_r;
    assign q.empty = empty_r;

`ifdef QUEUE_FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= q.push && full_r && !q.pop;
            underflow_r <= q.pop && empty_r;
        end
    end

    assign q.overflow  = overflow_r;
    assign q.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// ---------------------------------------------------------------------------
// tb_queue_fifo : directed checks for queue_fifo (WIDTH=16, DEPTH=16).
// ---------------------------------------------------------------------------
module tb_queue_fifo;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    queue_fifo_if #(.WIDTH(16), .ADDR_W(4)) qif ();

    queue_fifo #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .q     (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic op(input logic ps, input logic pp, input logic [15:0] d);
        qif.push = ps;
        qif.pop  = pp;
        qif.data = d;
        @(posedge clk);
        #1;
        qif.push = 1'b0;
        qif.pop  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        qif.push = 1'b0;
        qif.pop  = 1'b0;
        qif.data = '0;
        rst_n = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",   32'(qif.out),   32'h0);
        chk("rst_count", 32'(qif.count), 32'd0);
        chk("rst_empty", 32'(qif.empty), 32'd1);
        chk("rst_full",  32'(qif.full),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, 1'b0, 16'h0);
        chk("idle_empty", 32'(qif.empty), 32'd1);
`ifdef QUEUE_FIFO_ERR_EN
        chk("idle_ovf", 32'(qif.overflow),  32'd0);
        chk("idle_unf", 32'(qif.underflow), 32'd0);
`endif

        // Order check
        op(1'b1, 1'b0, 16'h1111);
        chk("ord_empty1", 32'(qif.empty), 32'd0);
        op(1'b1, 1'b0, 16'h2222);
        op(1'b1, 1'b0, 16'h3333);
        chk("ord_count3", 32'(qif.count), 32'd3);
        op(1'b0, 1'b1, 16'h0);
        chk("ord_pop1", 32'(qif.out), 32'h1111);
        chk("ord_cnt2", 32'(qif.count), 32'd2);
        op(1'b0, 1'b1, 16'h0);
        chk("ord_pop2", 32'(qif.out), 32'h2222);
        op(1'b0, 1'b1, 16'h0);
        chk("ord_pop3", 32'(qif.out), 32'h3333);
        chk("ord_cnt0", 32'(qif.count), 32'd0);
        chk("ord_empty", 32'(qif.empty), 32'd1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 16'(i));
        chk("fill_full",  32'(qif.full),  32'd1);
        chk("fill_count", 32'(qif.count), 32'd16);
        op(1'b1, 1'b0, 16'hFFFF);
        chk("ovf_count", 32'(qif.count), 32'd16);
        chk("ovf_full",  32'(qif.full),  32'd1);
`ifdef QUEUE_FIFO_ERR_EN
        chk("ovf_pulse", 32'(qif.overflow), 32'd1);
        op(1'b0, 1'b0, 16'h0);
        chk("ovf_clear", 32'(qif.overflow), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 16'h0);
            chk($sformatf("drain_%0d", i), 32'(qif.out), 32'(i));
        end
        chk("drain_empty", 32'(qif.empty), 32'd1);
        chk("drain_full",  32'(qif.full),  32'd0);

        // Wrap-around: write pointer starts at 3, so 30 pushes cross 15 -> 0
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 16'(16'h0100 + r*10 + i));
            chk($sformatf("wrap_cnt_%0d", r), 32'(qif.count), 32'd10);
            for (int i = 0; i < 10; i++) begin
                op(1'b0, 1'b1, 16'h0);
                chk($sformatf("wrap_%0d_%0d", r, i), 32'(qif.out), 32'(16'h0100 + r*10 + i));
            end
        end
        chk("wrap_cnt0", 32'(qif.count), 32'd0);

        // Simultaneous push+pop while empty: pop ignored, no bypass
        op(1'b1, 1'b1, 16'hAAAA);
        chk("se_count", 32'(qif.count), 32'd1);
        chk("se_out",   32'(qif.out),   32'h011D);
`ifdef QUEUE_FIFO_ERR_EN
        chk("se_unf", 32'(qif.underflow), 32'd1);
`endif
        op(1'b0, 1'b1, 16'h0);
        chk("se_pop", 32'(qif.out), 32'hAAAA);

        // Simultaneous push+pop while full
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 16'(16'hC000 + i));
        op(1'b1, 1'b1, 16'hBEEF);
        chk("sf_out",   32'(qif.out),   32'hC000);
        chk("sf_count", 32'(qif.count), 32'd16);
        chk("sf_full",  32'(qif.full),  32'd1);
`ifdef QUEUE_FIFO_ERR_EN
        chk("sf_ovf", 32'(qif.overflow), 32'd0);
`endif
        for (int i = 1; i < 16; i++) begin
            op(1'b0, 1'b1, 16'h0);
            chk($sformatf("sf_drain_%0d", i), 32'(qif.out), 32'(16'hC000 + i));
        end
        op(1'b0, 1'b1, 16'h0);
        chk("sf_last", 32'(qif.out), 32'hBEEF);
        chk("sf_empty", 32'(qif.empty), 32'd1);

        // Async reset mid-stream
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 16'(16'h5000 + i));
        chk("ar_count5", 32'(qif.count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_empty", 32'(qif.empty), 32'd1);
        chk("ar_count", 32'(qif.count), 32'd0);
        chk("ar_out",   32'(qif.out),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, 1'b1, 16'h0);
        chk("ar_pop_out",   32'(qif.out),   32'h0);
        chk("ar_pop_count", 32'(qif.count), 32'd0);
`ifdef QUEUE_FIFO_ERR_EN
        chk("ar_unf", 32'(qif.underflow), 32'd1);
`endif
        // Queue is usable again after reset
        op(1'b1, 1'b0, 16'h7777);
        op(1'b0, 1'b1, 16'h0);
        chk("ar_reuse", 32'(qif.out), 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
